// File: rtl/feed_time_setter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : feed_time_setter
//  Purpose  : Operator-side writer for the feeder's set-time bus. Debounces
//             four pushbuttons and runs an edit FSM over an HH:MM:SS BCD
//             working copy. Saving commits the working copy to the set-time
//             outputs, then drives an active-low nLoad strobe.
//  Ports    : Clk, Rst (sync, active-high)
//             btn_mode/btn_inc/btn_dec/btn_save : raw async buttons, active-high
//             shour2/1, sminute2/1, ssecond2/1  : committed time, BCD tens/units
//             nLoad     : load strobe, active-low
//             editing   : high while a field is being edited
//             field_sel : 0 none, 1 hour, 2 minute, 3 second
//  Revision : 1.0  initial release
// ============================================================================
module feed_time_setter #(
    parameter int DEBOUNCE_CYCLES     = 1_000_000,
    parameter int LOAD_PULSE_CYCLES   = 4,
    parameter int EDIT_TIMEOUT_CYCLES = 500_000_000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_save,
    output logic [3:0] shour2,
    output logic [3:0] shour1,
    output logic [3:0] sminute2,
    output logic [3:0] sminute1,
    output logic [3:0] ssecond2,
    output logic [3:0] ssecond1,
    output logic       nLoad,
    output logic       editing,
    output logic [1:0] field_sel
);

    localparam int c_DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_LD_W   = $clog2(LOAD_PULSE_CYCLES + 1);
    localparam int c_TO_W   = $clog2(EDIT_TIMEOUT_CYCLES + 1);
    localparam logic [c_DB_W-1:0] c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_LD_W-1:0] c_LD_LAST   = c_LD_W'(LOAD_PULSE_CYCLES - 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST   = c_TO_W'(EDIT_TIMEOUT_CYCLES - 1);
    localparam logic [7:0]        c_HOUR_MAX  = 8'h23;
    localparam logic [7:0]        c_MS_MAX    = 8'h59;
    localparam logic [7:0]        c_SENTINEL  = 8'h30;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EDIT_H = 3'd1,
        S_EDIT_M = 3'd2,
        S_EDIT_S = 3'd3,
        S_COMMIT = 3'd4,
        S_LOAD   = 3'd5
    } state_t;

    // ---------------------------------------------------------------- buttons
    // Bit order: 3 save, 2 mode, 1 inc, 0 dec
    logic [3:0] w_btn_raw;
    logic [3:0] w_press;
    assign w_btn_raw = {btn_save, btn_mode, btn_inc, btn_dec};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        logic [1:0]        r_sync;
        logic              r_stable;
        logic              r_pulse;
        logic [c_DB_W-1:0] r_cnt;

        // r_stable only flips after the synchronised level has disagreed with
        // it for DEBOUNCE_CYCLES in a row; a rising flip emits one pulse.
        always_ff @(posedge Clk) begin
            if (Rst) begin
                r_sync   <= 2'b00;
                r_stable <= 1'b0;
                r_pulse  <= 1'b0;
                r_cnt    <= '0;
            end else begin
                r_sync  <= {r_sync[0], w_btn_raw[i]};
                r_pulse <= 1'b0;
                if (r_sync[1] == r_stable) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DB_LAST) begin
                    r_stable <= r_sync[1];
                    r_cnt    <= '0;
                    r_pulse  <= r_sync[1];
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_press[i] = r_pulse;
    end

    logic w_save, w_mode, w_inc, w_dec, w_any;
    assign w_save = w_press[3];
    assign w_mode = w_press[2];
    assign w_inc  = w_press[1];
    assign w_dec  = w_press[0];
    assign w_any  = |w_press;

    // --------------------------------------------------------------- FSM
    state_t            r_state, w_state_nxt;
    logic [c_TO_W-1:0] r_idle_cnt;
    logic [c_LD_W-1:0] r_load_cnt;
    logic              w_step;
    logic              w_load_wc;
    logic [7:0]        r_wh, r_wm, r_ws;
    logic [7:0]        r_ch, r_cm, r_cs;

    always_ff @(posedge Clk) begin
        if (Rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step      = 1'b0;
        w_load_wc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mode) begin
                    w_state_nxt = S_EDIT_H;
                    w_load_wc   = 1'b1;
                end
            end
            S_EDIT_H, S_EDIT_M, S_EDIT_S: begin
                if (w_save) begin
                    w_state_nxt = S_COMMIT;
                end else if (w_mode) begin
                    case (r_state)
                        S_EDIT_H: w_state_nxt = S_EDIT_M;
                        S_EDIT_M: w_state_nxt = S_EDIT_S;
                        default:  w_state_nxt = S_EDIT_H;
                    endcase
                end else if (w_inc ^ w_dec) begin
                    w_step = 1'b1;
                end else if (!w_any && (r_idle_cnt == c_TO_LAST)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_COMMIT: w_state_nxt = S_LOAD;
            S_LOAD: begin
                if (r_load_cnt == c_LD_LAST) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            nLoad     <= 1'b1;
            editing   <= 1'b0;
            field_sel <= 2'd0;
        end else begin
            nLoad     <= (w_state_nxt != S_LOAD);
            editing   <= (w_state_nxt == S_EDIT_H) || (w_state_nxt == S_EDIT_M) ||
                         (w_state_nxt == S_EDIT_S);
            case (w_state_nxt)
                S_EDIT_H: field_sel <= 2'd1;
                S_EDIT_M: field_sel <= 2'd2;
                S_EDIT_S: field_sel <= 2'd3;
                default:  field_sel <= 2'd0;
            endcase
        end
    end

    // ---------------------------------------------------------- datapath
    function automatic logic [7:0] f_bcd_step(input logic [7:0] v, input logic up,
                                              input logic [7:0] vmax);
        logic [7:0] r;
        r = v;
        if (up) begin
            if (v == vmax)            r = 8'h00;
            else if (v[3:0] == 4'd9)  r = {v[7:4] + 4'd1, 4'd0};
            else                      r = {v[7:4], v[3:0] + 4'd1};
        end else begin
            if (v == 8'h00)           r = vmax;
            else if (v[3:0] == 4'd0)  r = {v[7:4] - 4'd1, 4'd9};
            else                      r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_idle_cnt <= '0;
            r_load_cnt <= '0;
            r_wh <= 8'h00;
            r_wm <= 8'h00;
            r_ws <= 8'h00;
            r_ch <= c_SENTINEL;
            r_cm <= 8'h00;
            r_cs <= 8'h00;
        end else begin
            // Idle timer only runs while editing and restarts on any press.
            if (editing && !w_any) r_idle_cnt <= r_idle_cnt + 1'b1;
            else                   r_idle_cnt <= '0;

            if (r_state == S_LOAD) r_load_cnt <= r_load_cnt + 1'b1;
            else                   r_load_cnt <= '0;

            if (w_load_wc) begin
                if (r_ch == c_SENTINEL) begin
                    r_wh <= 8'h00;
                    r_wm <= 8'h00;
                    r_ws <= 8'h00;
                end else begin
                    r_wh <= r_ch;
                    r_wm <= r_cm;
                    r_ws <= r_cs;
                end
            end else if (w_step) begin
                case (r_state)
                    S_EDIT_H: r_wh <= f_bcd_step(r_wh, w_inc, c_HOUR_MAX);
                    S_EDIT_M: r_wm <= f_bcd_step(r_wm, w_inc, c_MS_MAX);
                    default:  r_ws <= f_bcd_step(r_ws, w_inc, c_MS_MAX);
                endcase
            end

            // Commit on entry to COMMIT so the digits settle a full cycle
            // before nLoad falls.
            if (w_state_nxt == S_COMMIT) begin
                r_ch <= r_wh;
                r_cm <= r_wm;
                r_cs <= r_ws;
            end
        end
    end

    assign shour2   = r_ch[7:4];
    assign shour1   = r_ch[3:0];
    assign sminute2 = r_cm[7:4];
    assign sminute1 = r_cm[3:0];
    assign ssecond2 = r_cs[7:4];
    assign ssecond1 = r_cs[3:0];

endmodule
`default_nettype wire

// File: tb/tb_feed_time_setter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_feed_time_setter
//  Purpose  : Self-checking bench for feed_time_setter. A time-of-day model
//             (integer hours/minutes/seconds) predicts committed time, edit
//             state and strobe length for directed and random button presses.
//  Revision : 1.0  initial release
// ============================================================================
module tb_feed_time_setter;

    localparam int D = 4;
    localparam int L = 3;
    localparam int T = 50;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, btn_save = 1'b0;
    logic [3:0] shour2, shour1, sminute2, sminute1, ssecond2, ssecond1;
    logic       nLoad, editing;
    logic [1:0] field_sel;

    always #5 Clk = ~Clk;

    feed_time_setter #(
        .DEBOUNCE_CYCLES(D), .LOAD_PULSE_CYCLES(L), .EDIT_TIMEOUT_CYCLES(T)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_save(btn_save),
        .shour2(shour2), .shour1(shour1), .sminute2(sminute2), .sminute1(sminute1),
        .ssecond2(ssecond2), .ssecond1(ssecond1),
        .nLoad(nLoad), .editing(editing), .field_sel(field_sel)
    );

    int n_vec = 0;
    int n_err = 0;
    int low_cnt = 0;

    always @(negedge Clk) if (nLoad === 1'b0) low_cnt <= low_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model: plain clock arithmetic
    int c[3];       // committed h,m,s (hour 30 = unarmed)
    int w[3];       // working copy
    int mstate;     // 0 idle, 1..3 editing field
    int exp_low;

    function automatic logic [31:0] bcd_of(input int h, input int m, input int s);
        return {8'h0, 4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [31:0] dut_time();
        return {8'h0, shour2, shour1, sminute2, sminute1, ssecond2, ssecond1};
    endfunction

    task automatic model_reset();
        c = '{30, 0, 0};
        w = '{0, 0, 0};
        mstate = 0;
    endtask

    // m = {save, mode, inc, dec}
    task automatic model_apply(input logic [3:0] m);
        exp_low = 0;
        if (mstate == 0) begin
            if (m[2]) begin
                mstate = 1;
                if (c[0] == 30) w = '{0, 0, 0};
                else            w = c;
            end
        end else if (m[3]) begin
            c = w;
            mstate = 0;
            exp_low = L;
        end else if (m[2]) begin
            mstate = (mstate == 3) ? 1 : mstate + 1;
        end else if (m[1] != m[0]) begin
            int mx;
            int f;
            mx = (mstate == 1) ? 24 : 60;
            f  = mstate - 1;
            w[f] = m[1] ? (w[f] + 1) % mx : (w[f] + mx - 1) % mx;
        end
    endtask

    task automatic expect_all(input string tag);
        chk({tag, " time"}, dut_time(), bcd_of(c[0], c[1], c[2]));
        chk({tag, " editing"}, 32'(editing), 32'(mstate != 0));
        chk({tag, " field_sel"}, 32'(field_sel), 32'(mstate));
        chk({tag, " nLoad"}, 32'(nLoad), 32'd1);
    endtask

    task automatic drive(input logic [3:0] m);
        {btn_save, btn_mode, btn_inc, btn_dec} = m;
    endtask

    task automatic press(input logic [3:0] m, input string tag);
        int base;
        base = low_cnt;
        drive(m);
        repeat (12) @(negedge Clk);
        drive(4'b0000);
        repeat (10) @(negedge Clk);
        model_apply(m);
        expect_all(tag);
        chk({tag, " low cycles"}, 32'(low_cnt - base), 32'(exp_low));
    endtask

    // Save with cycle-level observation of the strobe.
    task automatic save_timed(input string tag);
        int k;
        int run;
        logic [31:0] prev_t;
        logic [31:0] hold_t;
        logic stable;
        k = 0;
        prev_t = dut_time();
        drive(4'b1000);
        while (k < 40) begin
            prev_t = dut_time();
            @(negedge Clk);
            k++;
            if (nLoad === 1'b0) break;
        end
        chk({tag, " strobe seen"}, 32'(nLoad === 1'b0), 32'd1);
        chk({tag, " save->nLoad latency ok"}, 32'((k >= D + 3) && (k <= D + 4)), 32'd1);
        chk({tag, " data before strobe"}, prev_t, bcd_of(w[0], w[1], w[2]));
        hold_t = dut_time();
        stable = 1'b1;
        run = 0;
        while ((nLoad === 1'b0) && (run < 20)) begin
            run++;
            if (dut_time() !== hold_t) stable = 1'b0;
            @(negedge Clk);
        end
        chk({tag, " low run"}, 32'(run), 32'(L));
        chk({tag, " data stable in strobe"}, 32'(stable), 32'd1);
        repeat (4) @(negedge Clk);
        drive(4'b0000);
        repeat (10) @(negedge Clk);
        model_apply(4'b1000);
        expect_all(tag);
    endtask

    localparam logic [3:0] c_MODE = 4'b0100, c_INC = 4'b0010, c_DEC = 4'b0001,
                           c_SAVE = 4'b1000;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] tbl[10];
        int base;
        int k;
        tbl = '{c_MODE, c_INC, c_INC, c_DEC, c_DEC, c_SAVE, 4'b0011, 4'b1010, 4'b0110, c_INC};

        // 1: reset
        model_reset();
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        expect_all("reset");

        // 2: set hour to 08 and save
        press(c_MODE, "enter edit");
        for (int i = 0; i < 8; i++) press(c_INC, "hour inc");
        save_timed("save 08");

        // 3: wrap-around on each field
        press(c_MODE, "edit h");
        for (int i = 0; i < 9; i++) press(c_DEC, "hour dec");
        press(c_MODE, "edit m");
        press(c_DEC, "min dec wrap");
        press(c_MODE, "edit s");
        press(c_DEC, "sec dec wrap");
        press(c_SAVE, "save 23:59:59");
        press(c_MODE, "edit h2");
        press(c_INC, "hour inc wrap");
        press(c_MODE, "edit m2");
        press(c_INC, "min inc wrap");
        press(c_MODE, "edit s2");
        press(c_INC, "sec inc wrap");
        press(c_SAVE, "save 00:00:00");
        press(c_MODE, "edit h3");
        press(c_DEC, "hour dec wrap");
        press(c_MODE, "edit m3");
        press(c_DEC, "min dec wrap2");
        press(c_MODE, "edit s3");
        press(c_DEC, "sec dec wrap2");
        press(c_SAVE, "save 23:59:59 again");

        // 4: glitch rejection and same-cycle priority
        press(c_MODE, "edit glitch");
        btn_inc = 1'b1;
        repeat (3) @(negedge Clk);
        btn_inc = 1'b0;
        repeat (6) @(negedge Clk);
        press(c_INC, "glitch then hold");
        press(4'b0011, "inc+dec");
        press(4'b1010, "save+inc");

        // 5: edit timeout abandons the working copy
        press(c_MODE, "edit timeout");
        press(c_INC, "inc before timeout");
        base = low_cnt;
        repeat (20) @(negedge Clk);
        expect_all("before timeout");
        repeat (40) @(negedge Clk);
        mstate = 0;
        expect_all("after timeout");
        chk("timeout low cycles", 32'(low_cnt - base), 32'd0);

        // 6: reset during the strobe
        press(c_MODE, "edit pre-reset");
        drive(4'b1000);
        k = 0;
        while ((nLoad !== 1'b0) && (k < 40)) begin
            @(negedge Clk);
            k++;
        end
        chk("reset test strobe seen", 32'(nLoad === 1'b0), 32'd1);
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        model_reset();
        chk("reset in LOAD nLoad", 32'(nLoad), 32'd1);
        chk("reset in LOAD time", dut_time(), bcd_of(30, 0, 0));
        chk("reset in LOAD editing", 32'(editing), 32'd0);
        Rst = 1'b0;
        drive(4'b0000);
        repeat (12) @(negedge Clk);
        press(c_MODE, "edit after reset");
        press(c_SAVE, "save after reset");

        // random presses
        for (int i = 0; i < 40; i++) begin
            press(tbl[$urandom_range(0, 9)], $sformatf("rand %0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
